sample_delay_line: RTL and testbench

- Parametrised successor to the PWM decoder's fixed two-stage sample buffer.
- Keeps a valid-qualified history of the last DEPTH signed samples.
- Presents the newest sample plus one selectable older sample, with fill tracking and flush.
- Sits between the sample source and the PWM edge/width logic; downstream uses current/prev pairs for comparisons.

---
 rtl/pwm_dec_pkg.sv | 14 +
 rtl/sample_hist_mux.sv | 21 ++
 rtl/sample_delay_line.sv | 124 ++++++++++++
 tb/tb_sample_delay_line.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dec_pkg.sv
// Shared types and helpers for the PWM decoder sample path.
package pwm_dec_pkg;

  localparam int DEFAULT_DATA_W = 16;

  typedef logic signed [DEFAULT_DATA_W-1:0] sample_t;
  typedef logic signed [DEFAULT_DATA_W:0]   delta_t;

  // An older-sample select may never reach past the oldest pre-shift entry.
  function automatic int clamp_sel(input int sel, input int depth);
    return (sel > depth - 2) ? depth - 2 : sel;
  endfunction

endpackage

// File: rtl/sample_hist_mux.sv
// Combinational DEPTH:1 history selector with the select clamped to the oldest
// usable entry; shared by the delay line and the edge detector.
module sample_hist_mux
  import pwm_dec_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] hist_i,
  input  logic [SEL_W-1:0]             sel_i,
  output logic [SEL_W-1:0]             eff_sel_o,
  output logic [DATA_W-1:0]            data_o
);

  always_comb begin
    eff_sel_o = SEL_W'(clamp_sel(int'(sel_i), DEPTH));
    data_o    = hist_i[eff_sel_o];
  end

endmodule

// File: rtl/sample_delay_line.sv
// Valid-qualified history of the last DEPTH signed samples with current/prev outputs.
// Define SAMPLE_DELAY_DELTA_EN to add the registered delta_out = data_in - selected sample.
module sample_delay_line
  import pwm_dec_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 4,
  localparam int SEL_W  = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  input  logic                     flush,
  input  logic [SEL_W-1:0]         delay_sel,
  output logic signed [DATA_W-1:0] current_out,
  output logic signed [DATA_W-1:0] prev_out,
  output logic                     out_valid,
  output logic                     primed,
  output logic [SEL_W:0]           fill_level
`ifdef SAMPLE_DELAY_DELTA_EN
  ,
  output logic signed [DATA_W:0]   delta_out
`endif
);

  logic [DEPTH-1:0][DATA_W-1:0] hist_q, hist_d;
  logic [DATA_W-1:0]            cur_q, cur_d;
  logic [DATA_W-1:0]            prev_q, prev_d;
  logic                         valid_q, valid_d;
  logic [SEL_W:0]               fill_q, fill_d;
  logic [SEL_W-1:0]             eff_sel;
  logic [DATA_W-1:0]            sel_data;
`ifdef SAMPLE_DELAY_DELTA_EN
  logic [DATA_W:0]              delta_q, delta_d;
`endif

  sample_hist_mux #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mux (
    .hist_i    (hist_q),
    .sel_i     (delay_sel),
    .eff_sel_o (eff_sel),
    .data_o    (sel_data)
  );

  // sel_data is read pre-shift, which is the entry eff_sel+1 once the new sample lands.
  always_comb begin
    hist_d  = hist_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    valid_d = 1'b0;
    fill_d  = fill_q;
`ifdef SAMPLE_DELAY_DELTA_EN
    delta_d = delta_q;
`endif
    if (flush) begin
      hist_d = '0;
      cur_d  = '0;
      prev_d = '0;
      fill_d = '0;
`ifdef SAMPLE_DELAY_DELTA_EN
      delta_d = '0;
`endif
      if (data_valid) begin
        hist_d[0] = data_in;
        cur_d     = data_in;
        valid_d   = 1'b1;
        fill_d    = (SEL_W+1)'(1);
`ifdef SAMPLE_DELAY_DELTA_EN
        delta_d   = {data_in[DATA_W-1], data_in};
`endif
      end
    end else if (data_valid) begin
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0] = data_in;
      cur_d     = data_in;
      prev_d    = sel_data;
      valid_d   = 1'b1;
      if (fill_q != (SEL_W+1)'(DEPTH)) begin
        fill_d = fill_q + (SEL_W+1)'(1);
      end
`ifdef SAMPLE_DELAY_DELTA_EN
      delta_d = {data_in[DATA_W-1], data_in} - {sel_data[DATA_W-1], sel_data};
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
      valid_q <= 1'b0;
      fill_q  <= '0;
`ifdef SAMPLE_DELAY_DELTA_EN
      delta_q <= '0;
`endif
    end else begin
      hist_q  <= hist_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
`ifdef SAMPLE_DELAY_DELTA_EN
      delta_q <= delta_d;
`endif
    end
  end

  // primed follows the live delay_sel, not the one captured at the last accept.
  assign primed      = fill_q >= ({1'b0, eff_sel} + (SEL_W+1)'(2));
  assign current_out = cur_q;
  assign prev_out    = prev_q;
  assign out_valid   = valid_q;
  assign fill_level  = fill_q;
`ifdef SAMPLE_DELAY_DELTA_EN
  assign delta_out   = delta_q;
`endif

endmodule

// File: tb/tb_sample_delay_line.sv
// Bench for sample_delay_line (DEPTH=4, DATA_W=16) against a queue-based history model.
// Delta checks are included when SAMPLE_DELAY_DELTA_EN is defined.
module tb_sample_delay_line;
  import pwm_dec_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int SEL_W  = 2;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  sample_t          data_in = '0;
  logic             data_valid = 1'b0;
  logic             flush = 1'b0;
  logic [SEL_W-1:0] delay_sel = '0;
  sample_t          current_out, prev_out;
  logic             out_valid, primed;
  logic [SEL_W:0]   fill_level;
`ifdef SAMPLE_DELAY_DELTA_EN
  delta_t           delta_out;
`endif

  int checks = 0;
  int errors = 0;

  // Model: every sample accepted since the last reset/flush, newest first.
  sample_t hist[$];
  sample_t exp_cur = '0;
  sample_t exp_prev = '0;
  logic    exp_valid = 1'b0;
  delta_t  exp_delta = '0;

  sample_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .flush       (flush),
    .delay_sel   (delay_sel),
    .current_out (current_out),
    .prev_out    (prev_out),
    .out_valid   (out_valid),
    .primed      (primed),
    .fill_level  (fill_level)
`ifdef SAMPLE_DELAY_DELTA_EN
    ,
    .delta_out   (delta_out)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic exp_primed();
    int k;
    k = (int'(delay_sel) > DEPTH - 2) ? DEPTH - 2 : int'(delay_sel);
    return (hist.size() >= k + 2);
  endfunction

  function automatic logic [SEL_W:0] exp_fill();
    return (SEL_W+1)'(hist.size());
  endfunction

  // Drives one clock of stimulus, advances the model, returns #1 after the edge.
  task automatic applyStimulus(input logic v, input sample_t d, input logic [SEL_W-1:0] s,
                               input logic f);
    int      k;
    sample_t pre;
    data_valid = v;
    data_in    = d;
    delay_sel  = s;
    flush      = f;
    exp_valid  = v;
    if (f) begin
      hist.delete();
      exp_cur   = '0;
      exp_prev  = '0;
      exp_delta = '0;
      if (v) begin
        exp_cur   = d;
        exp_delta = d;
        hist.push_front(d);
      end
    end else if (v) begin
      k   = (int'(s) > DEPTH - 2) ? DEPTH - 2 : int'(s);
      pre = (k < hist.size()) ? hist[k] : '0;
      exp_cur   = d;
      exp_prev  = pre;
      exp_delta = delta_t'(d) - delta_t'(pre);
      hist.push_front(d);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (current_out !== 16'sd0 || prev_out !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_data: cur=%0d prev=%0d required 0/0", current_out, prev_out);
    end
    checks++;
    if (out_valid !== 1'b0 || primed !== 1'b0 || fill_level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: valid=%b primed=%b fill=%0d required 0/0/0",
               out_valid, primed, fill_level);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    hist.delete();
    exp_cur = '0; exp_prev = '0; exp_valid = 1'b0; exp_delta = '0;
  endtask

  task automatic test_sequence();
    int pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, sample_t'(i), 2'd0, 1'b0);
      if (out_valid === 1'b1) pulses++;
      checks++;
      if (current_out !== exp_cur || prev_out !== exp_prev) begin
        errors++;
        $display("[TB] FAIL seq_data[%0d]: cur=%0d prev=%0d required %0d/%0d",
                 i, current_out, prev_out, exp_cur, exp_prev);
      end
    end
    checks++;
    if (current_out !== 16'sd5 || prev_out !== 16'sd4 || fill_level !== 3'd4 || primed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL seq_final: cur=%0d prev=%0d fill=%0d primed=%b required 5/4/4/1",
               current_out, prev_out, fill_level, primed);
    end
    applyStimulus(1'b0, 16'sd0, 2'd0, 1'b0);
    if (out_valid === 1'b1) pulses++;
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("[TB] FAIL seq_pulses: got %0d required 5", pulses);
    end
  endtask

  task automatic test_select_clamp();
    applyStimulus(1'b0, 16'sd0, 2'd2, 1'b1);
    applyStimulus(1'b1, 16'sd10, 2'd2, 1'b0);
    applyStimulus(1'b1, 16'sd20, 2'd2, 1'b0);
    applyStimulus(1'b1, 16'sd30, 2'd2, 1'b0);
    checks++;
    if (primed !== 1'b0 || primed !== exp_primed()) begin
      errors++;
      $display("[TB] FAIL sel_unprimed: primed=%b required 0", primed);
    end
    applyStimulus(1'b1, 16'sd40, 2'd2, 1'b0);
    checks++;
    if (current_out !== 16'sd40 || prev_out !== 16'sd10 || primed !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sel_primed: cur=%0d prev=%0d primed=%b required 40/10/1",
               current_out, prev_out, primed);
    end
    applyStimulus(1'b1, 16'sd50, 2'd3, 1'b0);
    checks++;
    if (prev_out !== 16'sd20 || prev_out !== exp_prev) begin
      errors++;
      $display("[TB] FAIL sel_clamp: prev=%0d required 20", prev_out);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, sample_t'($urandom), 2'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || current_out !== exp_cur || prev_out !== exp_prev) begin
        errors++;
        $display("[TB] FAIL gap_hold[%0d]: valid=%b cur=%0d prev=%0d required 0/%0d/%0d",
                 i, out_valid, current_out, prev_out, exp_cur, exp_prev);
      end
    end
    applyStimulus(1'b1, 16'sd60, 2'd0, 1'b0);
    checks++;
    if (prev_out !== 16'sd50 || current_out !== 16'sd60 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL gap_noshift: cur=%0d prev=%0d valid=%b required 60/50/1",
               current_out, prev_out, out_valid);
    end
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, -16'sd3, 2'd0, 1'b1);
    checks++;
    if (current_out !== -16'sd3 || prev_out !== 16'sd0 || fill_level !== 3'd1 ||
        out_valid !== 1'b1 || primed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_valid: cur=%0d prev=%0d fill=%0d valid=%b primed=%b required -3/0/1/1/0",
               current_out, prev_out, fill_level, out_valid, primed);
    end
    applyStimulus(1'b1, 16'sd9, 2'd0, 1'b0);
    applyStimulus(1'b0, 16'sd0, 2'd0, 1'b1);
    checks++;
    if (current_out !== 16'sd0 || prev_out !== 16'sd0 || fill_level !== 3'd0 ||
        out_valid !== 1'b0 || primed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_alone: cur=%0d prev=%0d fill=%0d valid=%b primed=%b required all 0",
               current_out, prev_out, fill_level, out_valid, primed);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, sample_t'($urandom), 2'd1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    hist.delete();
    exp_cur = '0; exp_prev = '0; exp_valid = 1'b0; exp_delta = '0;
    checks++;
    if (current_out !== 16'sd0 || prev_out !== 16'sd0 || out_valid !== 1'b0 ||
        primed !== 1'b0 || fill_level !== 3'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: cur=%0d prev=%0d valid=%b primed=%b fill=%0d required all 0",
               current_out, prev_out, out_valid, primed, fill_level);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(1'b1, 16'sd77, 2'd0, 1'b0);
    checks++;
    if (current_out !== 16'sd77 || prev_out !== 16'sd0 || fill_level !== 3'd1 || primed !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset: cur=%0d prev=%0d fill=%0d primed=%b required 77/0/1/0",
               current_out, prev_out, fill_level, primed);
    end
  endtask

`ifdef SAMPLE_DELAY_DELTA_EN
  task automatic test_delta();
    applyStimulus(1'b0, 16'sd0, 2'd0, 1'b1);
    applyStimulus(1'b1, -16'sd32768, 2'd0, 1'b0);
    applyStimulus(1'b1, 16'sd32767, 2'd0, 1'b0);
    checks++;
    if (delta_out !== 17'sd65535) begin
      errors++;
      $display("[TB] FAIL delta_extreme: got %0d required 65535", delta_out);
    end
  endtask
`endif

  task automatic test_random();
    logic    v, f;
    sample_t d;
    logic [SEL_W-1:0] s;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 15) == 0);
      s = SEL_W'($urandom_range(0, 3));
      d = sample_t'($urandom);
      applyStimulus(v, d, s, f);
      checks++;
      if (current_out !== exp_cur || prev_out !== exp_prev || out_valid !== exp_valid) begin
        errors++;
        $display("[TB] FAIL rand_data[%0d]: cur=%0d prev=%0d valid=%b required %0d/%0d/%b",
                 n, current_out, prev_out, out_valid, exp_cur, exp_prev, exp_valid);
      end
      checks++;
      if (fill_level !== exp_fill() || primed !== exp_primed()) begin
        errors++;
        $display("[TB] FAIL rand_fill[%0d]: fill=%0d primed=%b required %0d/%b",
                 n, fill_level, primed, exp_fill(), exp_primed());
      end
`ifdef SAMPLE_DELAY_DELTA_EN
      checks++;
      if (delta_out !== exp_delta) begin
        errors++;
        $display("[TB] FAIL rand_delta[%0d]: got %0d required %0d", n, delta_out, exp_delta);
      end
`endif
    end
  endtask

  initial begin
    $display("[TB] sample_delay_line bench start");
    test_reset();
    test_sequence();
    test_select_clamp();
    test_gaps();
    test_flush();
    test_reset_midstream();
`ifdef SAMPLE_DELAY_DELTA_EN
    test_delta();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
